// File: rtl/vdma_rd_line_sequencer.sv
// Read-side line sequencer for the VDMA pixel unpacker: align, stream, flush per line.
// Optional watchdog on the WAIT state is enabled with `define VDMA_SEQ_WDOG_EN.
module vdma_rd_line_sequencer #(
  parameter int PIX_W  = 16,
  parameter int LINE_W = 16,
  parameter int WCNT_W = 10,
  parameter int WDOG_W = 16
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [PIX_W-1:0]  hactive,
  input  logic [LINE_W-1:0] vactive,
  input  logic [WCNT_W-1:0] line_words,
  input  logic [WCNT_W-1:0] fifo_count,
  input  logic              fifo_empty,
  input  logic              dp_ird_en,
  input  logic              push_ready,
  output logic              dp_ialign,
  output logic              dp_force_rd,
  output logic              dp_ord_en,
  output logic              seq_pop,
  output logic              o_push,
  output logic              o_sof,
  output logic              o_eol,
  output logic              busy,
  output logic              frame_done,
  output logic              err_underflow,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ALIGN,
    S_STREAM,
    S_FLUSH
  } state_t;

  state_t            state;
  logic [PIX_W-1:0]  hactive_q;
  logic [PIX_W-1:0]  pix_cnt;
  logic [LINE_W-1:0] vactive_q;
  logic [LINE_W-1:0] line_cnt;
  logic [WCNT_W-1:0] line_words_q;
  logic [WCNT_W-1:0] word_cnt;
  logic              sof_pending;
  logic              wdog_force;
  logic              last_pix;
  logic              words_done;

  assign last_pix    = (pix_cnt == hactive_q - PIX_W'(1));
  assign words_done  = (word_cnt >= line_words_q);
  assign dp_ord_en   = (state == S_STREAM) & push_ready;
  // A word popped by the unpacker this cycle already advances the count, so skip our own pop.
  assign seq_pop     = (state == S_FLUSH) & ~words_done & ~dp_ird_en;
  assign dp_force_rd = ((state == S_FLUSH) & words_done) | wdog_force;
  assign busy        = (state != S_IDLE);

`ifdef VDMA_SEQ_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
`else
  assign wdog_force  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      hactive_q     <= '0;
      vactive_q     <= '0;
      line_words_q  <= '0;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      word_cnt      <= '0;
      sof_pending   <= 1'b0;
      dp_ialign     <= 1'b0;
      o_push        <= 1'b0;
      o_sof         <= 1'b0;
      o_eol         <= 1'b0;
      frame_done    <= 1'b0;
      err_underflow <= 1'b0;
`ifdef VDMA_SEQ_WDOG_EN
      wdog_cnt      <= '0;
      wdog_force    <= 1'b0;
      err_timeout   <= 1'b0;
`endif
    end else begin
      dp_ialign  <= 1'b0;
      frame_done <= 1'b0;
      o_push     <= dp_ord_en;
      o_sof      <= dp_ord_en & sof_pending;
      o_eol      <= dp_ord_en & last_pix;
      if ((dp_ird_en | seq_pop) & fifo_empty) err_underflow <= 1'b1;
`ifdef VDMA_SEQ_WDOG_EN
      wdog_cnt   <= '0;
      wdog_force <= 1'b0;
`endif

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            hactive_q    <= hactive;
            vactive_q    <= vactive;
            line_words_q <= line_words;
            line_cnt     <= '0;
            sof_pending  <= 1'b1;
            state        <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (fifo_count >= line_words_q) begin
            dp_ialign <= 1'b1;
            state     <= S_ALIGN;
          end
`ifdef VDMA_SEQ_WDOG_EN
          else if (&wdog_cnt) begin
            err_timeout <= 1'b1;
            wdog_force  <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
          end
`endif
        end

        S_ALIGN: begin
          pix_cnt  <= '0;
          word_cnt <= WCNT_W'(dp_ird_en);
          state    <= S_STREAM;
        end

        S_STREAM: begin
          if (dp_ird_en) word_cnt <= word_cnt + WCNT_W'(1);
          if (dp_ord_en) begin
            pix_cnt     <= pix_cnt + PIX_W'(1);
            sof_pending <= 1'b0;
            if (last_pix) state <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          // Below the line size exactly one word leaves per cycle: either the unpacker's or ours.
          if (!words_done) begin
            word_cnt <= word_cnt + WCNT_W'(1);
          end else begin
            line_cnt <= line_cnt + LINE_W'(1);
            if (line_cnt == vactive_q - LINE_W'(1)) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              state <= S_WAIT;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
